// File: rtl/lcg_stim_gen_if.sv
// lcg_stim_gen_if: control and stimulus bus of the LCG stimulus generator.
//   Controls (master -> slave): start, cycles, mode, pause, seed_load, seed.
//   Results  (slave -> master): stim_out, stim_valid, cyc_count, busy, done, rng_state_o.
// The generator connects through the slave modport; whoever drives it uses master.
interface lcg_stim_gen_if #(
    parameter int unsigned OUT_W = 135,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] cycles;
    logic [1:0]       mode;
    logic             pause;
    logic             seed_load;
    logic [31:0]      seed;

    logic [OUT_W-1:0] stim_out;
    logic             stim_valid;
    logic [CNT_W-1:0] cyc_count;
    logic             busy;
    logic             done;
    logic [31:0]      rng_state_o;

    modport master (
        output start, cycles, mode, pause, seed_load, seed,
        input  stim_out, stim_valid, cyc_count, busy, done, rng_state_o
    );

    modport slave (
        input  start, cycles, mode, pause, seed_load, seed,
        output stim_out, stim_valid, cyc_count, busy, done, rng_state_o
    );
endinterface

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: on-chip pseudo-random stimulus generator using the same LCG as the
// simulation flow (state = state * 0x41C64E6D + 0x3039, mod 2^32).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - lcg_stim_gen_if.slave: run controls in, registered stimulus/status out
// A run emits cycles+1 vectors, each built from ceil(OUT_W/32) chained LCG steps with the
// first step in the least-significant 32 bits.
module lcg_stim_gen #(
    parameter int unsigned OUT_W = 135,
    parameter logic [31:0] SEED  = 32'hDBE91D0A,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    lcg_stim_gen_if.slave bus
);
    localparam int unsigned K  = (OUT_W + 31) / 32;
    localparam int unsigned WW = K * 32;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {ModeLcg, ModeHold, ModeWalk, ModeToggle} mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [31:0]      rng_q, rng_d;
    logic [OUT_W-1:0] stim_q, stim_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             done_q, done_d;
    // Set while paused: the first unpaused cycle re-presents the held vector as valid.
    logic             held_q, held_d;

    logic [31:0]      lcg_base;
    logic [WW-1:0]    lcg_wide;

    // K chained steps; the top 32 bits are the K-th result, i.e. the new LCG state.
    function automatic logic [WW-1:0] lcg_build(input logic [31:0] s_in);
        logic [WW-1:0] v;
        logic [31:0]   s;
        v = '0;
        s = s_in;
        for (int j = 0; j < int'(K); j++) begin
            s = s * 32'h41C64E6D + 32'h0000_3039;
            v[32*j +: 32] = s;
        end
        return v;
    endfunction

    // A seed loaded on the same edge as start feeds vec0 directly.
    always_comb begin
        lcg_base = rng_q;
        if (state_q != StRun && bus.seed_load) begin
            lcg_base = bus.seed;
        end
        lcg_wide = lcg_build(lcg_base);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rng_d    = rng_q;
        stim_d   = stim_q;
        valid_d  = valid_q;
        cyc_d    = cyc_q;
        cycles_d = cycles_q;
        done_d   = done_q;
        held_d   = held_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.seed_load) begin
                    rng_d = bus.seed;
                end
                if (bus.start) begin
                    state_d  = StRun;
                    mode_d   = mode_e'(bus.mode);
                    cycles_d = bus.cycles;
                    cyc_d    = '0;
                    valid_d  = 1'b1;
                    done_d   = 1'b0;
                    held_d   = 1'b0;
                    if (mode_e'(bus.mode) == ModeWalk) begin
                        stim_d    = '0;
                        stim_d[0] = 1'b1;
                    end else begin
                        stim_d = lcg_wide[OUT_W-1:0];
                        rng_d  = lcg_wide[WW-1 -: 32];
                    end
                end
            end
            StRun: begin
                if (bus.pause) begin
                    valid_d = 1'b0;
                    held_d  = 1'b1;
                end else if (held_q) begin
                    valid_d = 1'b1;
                    held_d  = 1'b0;
                end else if (cyc_q == cycles_q) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                    unique case (mode_q)
                        ModeLcg: begin
                            stim_d = lcg_wide[OUT_W-1:0];
                            rng_d  = lcg_wide[WW-1 -: 32];
                        end
                        ModeHold: begin
                            stim_d = stim_q;
                        end
                        ModeWalk: begin
                            // Rotate left: one-hot position is (n mod OUT_W).
                            stim_d = (stim_q << 1) | (stim_q >> (OUT_W - 1));
                        end
                        ModeToggle: begin
                            // Current index even -> next is odd -> invert.
                            if (!cyc_q[0]) begin
                                stim_d = ~stim_q;
                            end else begin
                                stim_d = lcg_wide[OUT_W-1:0];
                                rng_d  = lcg_wide[WW-1 -: 32];
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= ModeLcg;
            rng_q    <= SEED;
            stim_q   <= '0;
            valid_q  <= 1'b0;
            cyc_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rng_q    <= rng_d;
            stim_q   <= stim_d;
            valid_q  <= valid_d;
            cyc_q    <= cyc_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            held_q   <= held_d;
        end
    end

    assign bus.stim_out    = stim_q;
    assign bus.stim_valid  = valid_q;
    assign bus.cyc_count   = cyc_q;
    assign bus.busy        = (state_q == StRun);
    assign bus.done        = done_q;
    assign bus.rng_state_o = rng_q;
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: three generators (OUT_W = 135, 40, 8) share one control stream.
// Expected vectors are pushed to a per-generator queue when a run is started and popped
// whenever a generator presents a new valid vector.
module tb_lcg_stim_gen;
    localparam int unsigned W_MAX = 135;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] SEED  = 32'hDBE91D0A;
    localparam int          NDUT  = 3;

    typedef logic [W_MAX-1:0] vec_t;
    typedef struct packed {
        logic [15:0] idx;
        vec_t        vec;
        logic [31:0] rng;
    } exp_t;
    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        done;
        logic [15:0] idx;
        logic [31:0] rng;
        vec_t        vec;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        seed_load;
    logic [15:0] cycles;
    logic [1:0]  mode;
    logic [31:0] seed;

    int          n_tests;
    int          n_fail;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        last_e[NDUT];
    logic        prev_busy[NDUT];
    logic [31:0] m_rng[NDUT];

    lcg_stim_gen_if #(.OUT_W(135), .CNT_W(CNT_W)) big_if ();
    lcg_stim_gen_if #(.OUT_W(40),  .CNT_W(CNT_W)) mid_if ();
    lcg_stim_gen_if #(.OUT_W(8),   .CNT_W(CNT_W)) sml_if ();

    assign big_if.start = start;  assign big_if.cycles = cycles;  assign big_if.mode = mode;
    assign big_if.pause = pause;  assign big_if.seed_load = seed_load;  assign big_if.seed = seed;
    assign mid_if.start = start;  assign mid_if.cycles = cycles;  assign mid_if.mode = mode;
    assign mid_if.pause = pause;  assign mid_if.seed_load = seed_load;  assign mid_if.seed = seed;
    assign sml_if.start = start;  assign sml_if.cycles = cycles;  assign sml_if.mode = mode;
    assign sml_if.pause = pause;  assign sml_if.seed_load = seed_load;  assign sml_if.seed = seed;

    lcg_stim_gen #(.OUT_W(135), .SEED(SEED), .CNT_W(CNT_W)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (big_if)
    );
    lcg_stim_gen #(.OUT_W(40), .SEED(SEED), .CNT_W(CNT_W)) u_mid (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mid_if)
    );
    lcg_stim_gen #(.OUT_W(8), .SEED(SEED), .CNT_W(CNT_W)) u_sml (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sml_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input vec_t act, input vec_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 135 : (d == 1) ? 40 : 8;
    endfunction

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h0000_3039;
    endfunction

    function automatic vec_t mask_w(input int w);
        vec_t m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Software reference: successive steps fill 32-bit chunks from the LSB up.
    function automatic vec_t model_vec(input int w, input logic [31:0] s_in,
                                       output logic [31:0] s_out);
        vec_t        v;
        logic [31:0] s;
        v = '0;
        s = s_in;
        for (int b = 0; b < w; b += 32) begin
            s = lcg_next(s);
            for (int i = 0; i < 32; i++) if (b + i < w) v[b+i] = s[i];
        end
        s_out = s;
        return v;
    endfunction

    task automatic push_run(input int d, input int cyc, input int md, input logic [31:0] base);
        int          w;
        logic [31:0] s;
        logic [31:0] ns;
        vec_t        v;
        vec_t        prev;
        exp_t        e;
        w    = width_of(d);
        s    = base;
        prev = '0;
        for (int n = 0; n <= cyc; n++) begin
            case (md)
                0: begin v = model_vec(w, s, ns); s = ns; end
                1: begin
                    if (n == 0) begin v = model_vec(w, s, ns); s = ns; end
                    else v = prev;
                end
                2: begin v = '0; v[n % w] = 1'b1; end
                default: begin
                    if (n % 2 == 0) begin v = model_vec(w, s, ns); s = ns; end
                    else v = ~prev & mask_w(w);
                end
            endcase
            e.idx = 16'(n);
            e.vec = v;
            e.rng = s;
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
            prev = v;
        end
        m_rng[d] = s;
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        case (d)
            0: begin
                o.valid = big_if.stim_valid; o.busy = big_if.busy; o.done = big_if.done;
                o.idx = big_if.cyc_count; o.rng = big_if.rng_state_o;
                o.vec = vec_t'(big_if.stim_out);
            end
            1: begin
                o.valid = mid_if.stim_valid; o.busy = mid_if.busy; o.done = mid_if.done;
                o.idx = mid_if.cyc_count; o.rng = mid_if.rng_state_o;
                o.vec = vec_t'(mid_if.stim_out);
            end
            default: begin
                o.valid = sml_if.stim_valid; o.busy = sml_if.busy; o.done = sml_if.done;
                o.idx = sml_if.cyc_count; o.rng = sml_if.rng_state_o;
                o.vec = vec_t'(sml_if.stim_out);
            end
        endcase
        return o;
    endfunction

    function automatic int sb_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon_step(input int d);
        obs_t o;
        exp_t e;
        o = observe(d);
        if (o.valid) begin
            if (!prev_busy[d] || o.idx != last_e[d].idx) begin
                if (sb_size(d) == 0) begin
                    check($sformatf("d%0d_sb_empty", d), vec_t'(sb_size(d)), vec_t'(1));
                end else begin
                    case (d)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    check($sformatf("d%0d_idx", d), vec_t'(o.idx), vec_t'(e.idx));
                    check($sformatf("d%0d_vec%0d", d, e.idx), o.vec, e.vec);
                    check($sformatf("d%0d_rng%0d", d, e.idx), vec_t'(o.rng), vec_t'(e.rng));
                    last_e[d] = e;
                end
            end else begin
                check($sformatf("d%0d_hold_vec", d), o.vec, last_e[d].vec);
            end
        end
        prev_busy[d] = o.busy;
    endtask

    // Sample on the falling edge, then the caller may change inputs.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) mon_step(d);
    endtask

    task automatic check_reset(input string tag);
        obs_t o;
        for (int d = 0; d < NDUT; d++) begin
            o = observe(d);
            check($sformatf("%s_d%0d_vec", tag, d), o.vec, vec_t'(0));
            check($sformatf("%s_d%0d_valid", tag, d), vec_t'(o.valid), vec_t'(0));
            check($sformatf("%s_d%0d_idx", tag, d), vec_t'(o.idx), vec_t'(0));
            check($sformatf("%s_d%0d_busy", tag, d), vec_t'(o.busy), vec_t'(0));
            check($sformatf("%s_d%0d_done", tag, d), vec_t'(o.done), vec_t'(0));
            check($sformatf("%s_d%0d_rng", tag, d), vec_t'(o.rng), vec_t'(SEED));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        for (int d = 0; d < NDUT; d++) m_rng[d] = SEED;
    endtask

    task automatic run(input int cyc, input int md, input logic ld, input logic [31:0] sd,
                       input int pause_at, input int pause_len, input int start_at);
        obs_t o;
        bit   paused;
        bit   restarted;
        for (int d = 0; d < NDUT; d++) push_run(d, cyc, md, ld ? sd : m_rng[d]);
        start     = 1'b1;
        cycles    = 16'(cyc);
        mode      = 2'(md);
        seed_load = ld;
        seed      = sd;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        paused    = 1'b0;
        restarted = 1'b0;
        for (int t = 0; t < 2 * cyc + pause_len + 20; t++) begin
            if (big_if.done) break;
            tick();
            o = observe(0);
            if (!paused && pause_at >= 0 && o.valid && int'(o.idx) == pause_at) begin
                pause  = 1'b1;
                paused = 1'b1;
                for (int k = 0; k < pause_len; k++) begin
                    tick();
                    for (int d = 0; d < NDUT; d++) begin
                        o = observe(d);
                        check($sformatf("pause_d%0d_valid", d), vec_t'(o.valid), vec_t'(0));
                        check($sformatf("pause_d%0d_idx", d), vec_t'(o.idx), vec_t'(pause_at));
                        check($sformatf("pause_d%0d_vec", d), o.vec, last_e[d].vec);
                        check($sformatf("pause_d%0d_rng", d), vec_t'(o.rng),
                              vec_t'(last_e[d].rng));
                    end
                end
                pause = 1'b0;
            end
            if (!restarted && start_at >= 0 && o.valid && int'(o.idx) == start_at) begin
                restarted = 1'b1;
                start = 1'b1;
                tick();
                start = 1'b0;
                o = observe(0);
                check("start_ignored_idx", vec_t'(o.idx), vec_t'(start_at + 1));
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            o = observe(d);
            check($sformatf("end_d%0d_done", d), vec_t'(o.done), vec_t'(1));
            check($sformatf("end_d%0d_busy", d), vec_t'(o.busy), vec_t'(0));
            check($sformatf("end_d%0d_idx", d), vec_t'(o.idx), vec_t'(cyc));
            check($sformatf("end_d%0d_rng", d), vec_t'(o.rng), vec_t'(m_rng[d]));
            check($sformatf("end_d%0d_sb_left", d), vec_t'(sb_size(d)), vec_t'(0));
        end
    endtask

    initial begin
        obs_t o;
        n_tests   = 0;
        n_fail    = 0;
        start     = 1'b0;
        pause     = 1'b0;
        seed_load = 1'b0;
        cycles    = '0;
        mode      = '0;
        seed      = '0;
        for (int d = 0; d < NDUT; d++) begin
            prev_busy[d] = 1'b0;
            last_e[d]    = '0;
        end
        do_reset();
        tick();
        check_reset("reset");

        // seed_load and start together; vec0 built from seed 1.
        run(0, 0, 1'b1, 32'd1, -1, 0, -1);
        o = observe(0);
        check("lit_vec64", o.vec & mask_w(64), vec_t'(64'h967EB0E7_41C67EA6));
        o = observe(1);
        check("lit_vec40", o.vec, vec_t'(40'hE7_41C67EA6));
        check("lit_rng40", vec_t'(o.rng), vec_t'(32'h967EB0E7));
        o = observe(2);
        check("lit_vec8", o.vec, vec_t'(8'hA6));
        check("lit_rng8", vec_t'(o.rng), vec_t'(32'h41C67EA6));

        // Long run from the reset seed, no seed_load.
        do_reset();
        run(150, 0, 1'b0, 32'd0, -1, 0, -1);

        // Pause for 5 cycles at index 3.
        run(10, 0, 1'b0, 32'd0, 3, 5, -1);

        // Walking one: 8-bit wraps after 0x80.
        run(9, 2, 1'b0, 32'd0, -1, 0, -1);
        o = observe(2);
        check("walk_last8", o.vec, vec_t'(8'h02));

        run(9, 3, 1'b0, 32'd0, -1, 0, -1);
        run(5, 1, 1'b0, 32'd0, -1, 0, -1);

        // start during RUN is ignored.
        run(12, 0, 1'b0, 32'd0, -1, 0, 5);

        // seed_load alone in DONE.
        seed_load = 1'b1;
        seed      = 32'h1234_5678;
        tick();
        seed_load = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            o = observe(d);
            check($sformatf("seedload_d%0d_rng", d), vec_t'(o.rng), vec_t'(32'h1234_5678));
            m_rng[d] = 32'h1234_5678;
        end

        // Reset in the middle of a run.
        for (int d = 0; d < NDUT; d++) push_run(d, 20, 0, m_rng[d]);
        start  = 1'b1;
        cycles = 16'd20;
        mode   = 2'd0;
        tick();
        start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            o = observe(0);
            if (int'(o.idx) == 7) break;
            tick();
        end
        o = observe(0);
        check("abort_reach_idx", vec_t'(o.idx), vec_t'(7));
        do_reset();
        check_reset("abort");
        tick();
        check_reset("abort_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
